// File: rtl/volt_pkg.sv
// ---------------------------------------------------------------------------
// volt_pkg
// Shared definitions for the ADC-to-BCD voltage converter.
//   - state_t      : top-level controller states (ACC/SCALE/CONV/DONE)
//   - BCD_MAX_X10  : largest value shown, two BCD digits (9.9 V)
//   - SCALE_SHIFT  : fixed-point shift applied after the VREF multiply
//   - ROUND_HALF   : half an LSB at SCALE_SHIFT, added for round-to-nearest
// ---------------------------------------------------------------------------
package volt_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_SCALE = 2'd1,
        ST_CONV  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]  BCD_MAX_X10 = 8'd99;
    localparam int          SCALE_SHIFT = 8;
    localparam logic [15:0] ROUND_HALF  = 16'd128;

endpackage

// File: rtl/bin2bcd_dd.sv
// ---------------------------------------------------------------------------
// bin2bcd_dd
// Serial 8-bit double-dabble converter. One shift per clock, eight shifts per
// conversion. The input is expected to be at most 99, so two BCD digits are
// enough to hold the result.
//
// Ports:
//   clk_in    input   1  system clock
//   rst_n_in  input   1  asynchronous active-low reset
//   i_load    input   1  load i_bin, clear the BCD field, start converting
//   i_bin     input   8  binary value to convert (0..99)
//   o_bcd     output  8  BCD shift field, {tens, units}; final after o_done
//   o_done    output  1  high during the cycle whose edge does the last shift
// ---------------------------------------------------------------------------
module bin2bcd_dd (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       i_load,
    input  logic [7:0] i_bin,
    output logic [7:0] o_bcd,
    output logic       o_done
);

    logic [7:0] r_bin;
    logic [7:0] r_bcd;
    logic [2:0] r_iter;
    logic       r_busy;

    logic [7:0] w_bcdAdj;

    // Add-3 correction: any digit of 5 or more would become >= 10 after the
    // doubling shift, so bias it by 3 so the carry lands in the next digit.
    always_comb begin
        w_bcdAdj = r_bcd;
        if (r_bcd[7:4] >= 4'd5) begin
            w_bcdAdj[7:4] = r_bcd[7:4] + 4'd3;
        end
        if (r_bcd[3:0] >= 4'd5) begin
            w_bcdAdj[3:0] = r_bcd[3:0] + 4'd3;
        end
    end

    // Shift engine. A load restarts the conversion from scratch; otherwise
    // while busy the combined {bcd, bin} register is shifted left once per
    // clock and the iteration counter stops the engine after eight shifts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_bin  <= 8'd0;
            r_bcd  <= 8'd0;
            r_iter <= 3'd0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_bin  <= i_bin;
            r_bcd  <= 8'd0;
            r_iter <= 3'd0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            {r_bcd, r_bin} <= {w_bcdAdj[6:0], r_bin, 1'b0};
            r_iter         <= r_iter + 3'd1;
            if (r_iter == 3'd7) begin
                r_busy <= 1'b0;
            end
        end
    end

    // The last shift is flagged one cycle early so the controller can step
    // into its output state on the same edge the final shift completes.
    assign o_done = r_busy && (r_iter == 3'd7);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/volt_bcd_conv.sv
// ---------------------------------------------------------------------------
// volt_bcd_conv
// Averages 2^AVG_LOG2 raw ADC samples, scales the mean to volts x10 against
// VREF_X10, converts it to two BCD digits and presents a held BCD byte with a
// one-cycle update strobe.
//
// Parameters:
//   AVG_LOG2  log2 of samples per average (0..8)
//   VREF_X10  ADC full-scale reference in tenths of a volt (1..127)
//
// Ports:
//   clk_in     input   1  system clock
//   rst_n_in   input   1  asynchronous active-low reset
//   adc_valid  input   1  single-cycle strobe, adc_data valid
//   adc_data   input   8  raw unsigned ADC code
//   adc_ready  output  1  high while samples are accepted (state ACC)
//   BCD        output  8  {volts digit, tenths digit}, held between updates
//   bcd_valid  output  1  one-cycle pulse when BCD is updated
//
// Build option:
//   VOLT_HYST_EN  when defined, an update whose value is within 1 of the
//                 value currently shown is suppressed (no write, no strobe).
//                 The first conversion after reset always updates.
// ---------------------------------------------------------------------------
module volt_bcd_conv
    import volt_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int VREF_X10 = 33
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       adc_valid,
    input  logic [7:0] adc_data,
    output logic       adc_ready,
    output logic [7:0] BCD,
    output logic       bcd_valid
);

    localparam int SUM_W = 8 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'((1 << AVG_LOG2) - 1);

    state_t           r_state;
    state_t           w_nextState;

    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_bcd;
    logic             r_bcdValid;

    logic             w_accept;
    logic             w_lastSample;
    logic             w_load;
    logic             w_ready;
    logic [7:0]       w_mean;
    logic [14:0]      w_prod;
    logic [15:0]      w_rounded;
    logic [7:0]       w_scaled;
    logic [7:0]       w_v;
    logic [7:0]       w_convBcd;
    logic             w_convDone;

    assign w_accept     = adc_valid && (r_state == ST_ACC);
    assign w_lastSample = (r_count == LAST_COUNT);

    // Scaling path, evaluated combinationally and consumed in SCALE.
    // The sum cannot overflow, so the mean is simply the top 8 bits of it.
    // mean*VREF_X10 fits 15 bits for the allowed parameter range.
    assign w_mean    = 8'(r_sum >> AVG_LOG2);
    assign w_prod    = 15'(w_mean) * 15'(VREF_X10);
    assign w_rounded = {1'b0, w_prod} + ROUND_HALF;
    assign w_scaled  = 8'(w_rounded >> SCALE_SHIFT);
    assign w_v       = (w_scaled > BCD_MAX_X10) ? BCD_MAX_X10 : w_scaled;

    bin2bcd_dd u_bin2bcd (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_load   (w_load),
        .i_bin    (w_v),
        .o_bcd    (w_convBcd),
        .o_done   (w_convDone)
    );

    // Controller state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control decode. The converter is loaded during SCALE,
    // runs its eight shifts during CONV, and DONE is the single output cycle.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_ready = 1'b1;
                if (w_accept && w_lastSample) begin
                    w_nextState = ST_SCALE;
                end
            end
            ST_SCALE: begin
                w_load      = 1'b1;
                w_nextState = ST_CONV;
            end
            ST_CONV: begin
                if (w_convDone) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_ACC;
            end
            default: begin
                w_nextState = ST_ACC;
            end
        endcase
    end

    // Accumulator. The sum is held through SCALE so the mean can be taken,
    // and is only cleared in DONE ready for the next window. Samples that
    // arrive outside ACC are ignored rather than queued.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sum   <= '0;
            r_count <= '0;
        end else if (r_state == ST_DONE) begin
            r_sum   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_sum   <= r_sum + SUM_W'(adc_data);
            r_count <= r_count + CNT_W'(1);
        end
    end

`ifdef VOLT_HYST_EN
    logic [6:0] r_vNew;
    logic [6:0] r_shown;
    logic       r_shownValid;
    logic [6:0] w_diff;
    logic       w_update;

    // Distance between the fresh result and the value on display; an update
    // is needed when it exceeds one count or nothing has been shown yet.
    assign w_diff   = (r_vNew > r_shown) ? (r_vNew - r_shown) : (r_shown - r_vNew);
    assign w_update = !r_shownValid || (w_diff > 7'd1);

    // Output registers with hysteresis. The binary result is captured in
    // SCALE alongside the converter load so DONE can compare it against the
    // shown value without decoding BCD back to binary.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vNew       <= 7'd0;
            r_shown      <= 7'd0;
            r_shownValid <= 1'b0;
            r_bcd        <= 8'h00;
            r_bcdValid   <= 1'b0;
        end else begin
            r_bcdValid <= 1'b0;
            if (r_state == ST_SCALE) begin
                r_vNew <= 7'(w_v);
            end
            if ((r_state == ST_DONE) && w_update) begin
                r_bcd        <= w_convBcd;
                r_bcdValid   <= 1'b1;
                r_shown      <= r_vNew;
                r_shownValid <= 1'b1;
            end
        end
    end
`else
    // Output registers. BCD only ever changes in DONE, and the strobe is a
    // single-cycle pulse that follows that write.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_bcd      <= 8'h00;
            r_bcdValid <= 1'b0;
        end else begin
            r_bcdValid <= 1'b0;
            if (r_state == ST_DONE) begin
                r_bcd      <= w_convBcd;
                r_bcdValid <= 1'b1;
            end
        end
    end
`endif

    assign adc_ready = w_ready;
    assign BCD       = r_bcd;
    assign bcd_valid = r_bcdValid;

endmodule
